// File: rtl/scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_decoder_pkg
// Description : Shared types and helpers for the scan_decoder block. Holds the
//               FSM state type, the mode-pin encodings and a one-hot helper
//               usable at any select width up to c_MAX_SEL_W.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select the helper supports; callers size-cast in and out.
    localparam int c_MAX_SEL_W = 8;
    localparam int c_MAX_OUT_W = 2 ** c_MAX_SEL_W;

    function automatic logic [c_MAX_OUT_W-1:0] onehot(input logic [c_MAX_SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : dwell_timer
// Description : Loadable down-counter pacing the scan steps. The count parks
//               at zero and zero is flagged combinationally so the owner can
//               step and reload in the same cycle.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset
//               clr   - synchronous clear to zero (highest priority)
//               load  - load counter from dwell
//               en    - decrement enable
//               dwell - reload value
//               zero  - counter currently reads zero
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer
    import scan_decoder_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    output logic               zero
);

    logic [DWELL_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= dwell;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - DWELL_W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : scan_decoder
// Description : Binary-to-one-hot decoder with registered output. Direct mode
//               decodes codes accepted over a valid/ready port; scan mode
//               walks the active line across all outputs with a programmable
//               dwell. en low blanks the output and parks the FSM.
// Ports       : clk     - clock
//               rst_n   - asynchronous active-low reset
//               en      - block enable
//               mode    - 0 direct, 1 scan
//               a       - select code (direct mode)
//               a_valid - a is valid
//               a_ready - code accepted when a_valid && a_ready
//               dwell   - cycles per scan step minus one
//               y       - one-hot output (registered)
//               idx     - binary index of active line (registered)
//               wrap    - pulse when scan returns to line 0
// Revision    : 1.0 - initial release
// ============================================================================
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = 2,   // must not exceed c_MAX_SEL_W
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      a,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(2**SEL_W)-1:0] y,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int OUT_W = 2 ** SEL_W;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_a_ready;
    logic               w_xfer;
    logic               w_scan_entry;
    logic               w_tmr_clr;
    logic               w_tmr_load;
    logic               w_tmr_en;
    logic               w_tmr_zero;
    logic [SEL_W-1:0]   w_idx_inc;
    logic [SEL_W-1:0]   r_idx;
    logic [OUT_W-1:0]   r_y;
    logic               r_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The next state depends only on en/mode, so every output register is
    // updated from the state the block is about to enter; this gives the
    // one-cycle reaction to blanking and mode changes.
    always_comb begin
        w_state_nxt  = IDLE;
        w_a_ready    = 1'b0;
        w_xfer       = 1'b0;
        w_scan_entry = 1'b0;
        w_tmr_clr    = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_en     = 1'b0;
        if (en) begin
            w_state_nxt = (mode == MODE_SCAN) ? SCAN : DIRECT;
        end
        w_a_ready    = en && (mode == MODE_DIRECT);
        w_xfer       = a_valid && w_a_ready;
        w_scan_entry = (w_state_nxt == SCAN) && (r_state != SCAN);
        w_tmr_clr    = (w_state_nxt == IDLE);
        w_tmr_en     = (w_state_nxt == SCAN);
        // Reload on entry and on every step, so a new dwell lands at the next step.
        w_tmr_load   = w_scan_entry || (w_tmr_en && w_tmr_zero);
    end

    assign w_idx_inc = r_idx + SEL_W'(1);

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_tmr_clr),
        .load  (w_tmr_load),
        .en    (w_tmr_en),
        .dwell (dwell),
        .zero  (w_tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y    <= '0;
            r_idx  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (w_state_nxt)
                IDLE: begin
                    r_y   <= '0;
                    r_idx <= '0;
                end
                DIRECT: begin
                    if (w_xfer) begin
                        r_idx <= a;
                        r_y   <= OUT_W'(onehot(c_MAX_SEL_W'(a)));
                    end
                end
                SCAN: begin
                    if (w_scan_entry) begin
                        r_idx <= '0;
                        r_y   <= OUT_W'(1);
                    end else if (w_tmr_zero) begin
                        r_idx  <= w_idx_inc;
                        r_y    <= OUT_W'(onehot(c_MAX_SEL_W'(w_idx_inc)));
                        // Stepping off the last line is the return to line 0.
                        r_wrap <= &r_idx;
                    end
                end
                default: begin
                    r_y   <= '0;
                    r_idx <= '0;
                end
            endcase
        end
    end

    assign a_ready = w_a_ready;
    assign y       = r_y;
    assign idx     = r_idx;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_decoder
// Description : Self-checking bench for scan_decoder. Two instances (SEL_W=2
//               and SEL_W=3) share control inputs and are compared every cycle
//               against a cycle-count based reference model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic       a_valid;
    logic [1:0] a2;
    logic [2:0] a3;
    logic [7:0] dwell;

    logic       ar2, ar3;
    logic [3:0] y2;
    logic [7:0] y3;
    logic [1:0] idx2;
    logic [2:0] idx3;
    logic       wrap2, wrap3;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: per instance, phase (0 idle, 1 direct, 2 scan),
    // edges since scan entry, dwell captured at entry, and expected outputs.
    int c_lines [2] = '{4, 8};
    int m_ph    [2];
    int m_k     [2];
    int m_d     [2];
    int m_idx   [2];
    int m_on    [2];
    int m_wrap  [2];

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(2), .DWELL_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a2), .a_valid(a_valid),
        .a_ready(ar2), .dwell(dwell), .y(y2), .idx(idx2), .wrap(wrap2)
    );

    scan_decoder #(.SEL_W(3), .DWELL_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a3), .a_valid(a_valid),
        .a_ready(ar3), .dwell(dwell), .y(y3), .idx(idx3), .wrap(wrap3)
    );

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_ph[w] = 0; m_k[w] = 0; m_d[w] = 0;
            m_idx[w] = 0; m_on[w] = 0; m_wrap[w] = 0;
        end
    endtask

    task automatic model_step();
        for (int w = 0; w < 2; w++) begin
            int av;
            av = (w == 0) ? int'(a2) : int'(a3);
            m_wrap[w] = 0;
            if (!en) begin
                m_ph[w] = 0; m_idx[w] = 0; m_on[w] = 0;
            end else if (!mode) begin
                m_ph[w] = 1;
                if (a_valid) begin
                    m_idx[w] = av; m_on[w] = 1;
                end
            end else begin
                if (m_ph[w] != 2) begin
                    m_k[w] = 0; m_d[w] = int'(dwell);
                end else begin
                    m_k[w]++;
                end
                m_ph[w]  = 2;
                m_on[w]  = 1;
                m_idx[w] = (m_k[w] / (m_d[w] + 1)) % c_lines[w];
                m_wrap[w] = (m_k[w] > 0 && (m_k[w] % (m_d[w] + 1)) == 0 && m_idx[w] == 0) ? 1 : 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at t=%0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] e2, e3, er;
        e2 = (m_on[0] != 0) ? (32'd1 << m_idx[0]) : 32'd0;
        e3 = (m_on[1] != 0) ? (32'd1 << m_idx[1]) : 32'd0;
        er = {31'd0, en && !mode};
        chk("y_sel2",     32'(y2),    e2);
        chk("idx_sel2",   32'(idx2),  32'(m_idx[0]));
        chk("wrap_sel2",  32'(wrap2), 32'(m_wrap[0]));
        chk("ready_sel2", 32'(ar2),   er);
        chk("y_sel3",     32'(y3),    e3);
        chk("idx_sel3",   32'(idx3),  32'(m_idx[1]));
        chk("wrap_sel3",  32'(wrap3), 32'(m_wrap[1]));
        chk("ready_sel3", 32'(ar3),   er);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        // Reset and disabled idle.
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; a_valid = 1'b0;
        a2 = '0; a3 = '0; dwell = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        repeat (2) cyc();

        // Direct transfers a=2 then a=3, then hold.
        en = 1'b1; mode = 1'b0; a_valid = 1'b1; a2 = 2'd2; a3 = 3'd2;
        cyc();
        a2 = 2'd3; a3 = 3'd3;
        cyc();
        a_valid = 1'b0; a2 = 2'd0; a3 = 3'd5;
        repeat (2) cyc();

        // Scan with dwell = 2: each line held 3 cycles, wrap on return.
        mode = 1'b1; dwell = 8'd2;
        repeat (16) cyc();

        // Leave scan briefly (hold), then scan with dwell = 0.
        mode = 1'b0;
        cyc();
        dwell = 8'd0; mode = 1'b1;
        repeat (18) cyc();

        // Drop en when the 4-line instance sits on line 2.
        for (int i = 0; i < 8 && m_idx[0] != 2; i++) cyc();
        en = 1'b0;
        cyc();
        en = 1'b1;
        repeat (6) cyc();

        // Asynchronous reset mid-scan: outputs clear before the next edge.
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst_n = 1'b1;
        repeat (5) cyc();

        // Scan -> direct with a simultaneous transfer of a=1.
        mode = 1'b0; a_valid = 1'b1; a2 = 2'd1; a3 = 3'd1;
        cyc();
        a_valid = 1'b0;
        cyc();

        // Randomised traffic; dwell only changes while not scanning.
        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            a_valid = $urandom_range(0, 1) == 1;
            a2      = 2'($urandom_range(0, 3));
            a3      = 3'($urandom_range(0, 7));
            if (!en || !mode) dwell = 8'($urandom_range(0, 3));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scan_decoder.md
# scan_decoder

Parametrised binary-to-one-hot decoder with a registered output, a valid/ready input port and an autonomous scan mode. In direct mode it decodes an accepted select code, like the combinational 2-to-4 enable decoder it succeeds, but with a one-cycle registered output and held state. In scan mode it walks the one-hot output across all lines with a programmable dwell. It sits between control logic and multiplexed loads such as LED/display row drivers, bank selects and chip-select fans.

## Interface
Parameters:
- SEL_W, default 2: select width; output width OUT_W = 2**SEL_W (localparam, not overridable).
- DWELL_W, default 8: width of the dwell-count input.

Ports:
- clk  in  1  single clock for all state.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  block enable; low blanks the output and parks the FSM.
- mode  in  1  0 = direct, 1 = scan.
- a  in  SEL_W  select code (direct mode).
- a_valid  in  1  a is valid.
- a_ready  out  1  transfer accepted when a_valid && a_ready.
- dwell  in  DWELL_W  cycles per scan step, minus one.
- y  out  OUT_W  one-hot output, registered.
- idx  out  SEL_W  binary index of the active line, registered.
- wrap  out  1  one-cycle pulse when scan returns from OUT_W-1 to 0.

## Operation
- FSM states are IDLE, DIRECT and SCAN. The next state is evaluated every cycle:
  - !en gives IDLE.
  - en && !mode gives DIRECT.
  - en && mode gives SCAN.
- a_ready = en && !mode, combinational. It is never high in scan mode or when disabled.
- IDLE:
  - y = 0, idx = 0, wrap = 0.
  - Dwell counter cleared.
- DIRECT:
  - On each accepted transfer: y <= 1 << a, idx <= a.
  - Without a transfer, y and idx hold their last values.
  - On entry from IDLE, y stays 0 until the first transfer.
  - On entry from SCAN, the current y/idx are held until the first transfer.
- SCAN:
  - On entry (from IDLE or DIRECT): idx <= 0, y <= 1, and the dwell counter is loaded with dwell.
  - The dwell counter decrements each cycle. When it reads 0, idx <= idx+1 (mod OUT_W), y follows, and the counter reloads from the current dwell.
  - dwell is sampled only at load, so changes take effect at the next step.
  - When idx steps from OUT_W-1 to 0, wrap = 1 for that one cycle.
- y is always either all-zero or exactly one-hot, and y == 1 << idx whenever y != 0.

## Timing
- Reset values: y = 0, idx = 0, wrap = 0, state IDLE. a_ready follows its inputs.
- Direct latency: a transfer in cycle N drives y/idx in cycle N+1.
- Blanking: en falling in cycle N gives y = 0 in cycle N+1. en low has priority over everything.
- Mode change in cycle N: the new state is active in cycle N+1. Scan restarts at idx 0, never resuming.
- Scan step period is dwell+1 cycles. dwell = 0 advances every cycle. Full sweep takes OUT_W*(dwell+1) cycles.
- wrap is asserted in the same cycle y returns to line 0. It is never asserted on scan entry.
- Reset asserted mid-scan or mid-transfer clears all state immediately and asynchronously. Release resumes in IDLE, and the first active cycle follows the rules above.
- a_valid without a_ready drops the code: the block keeps no input buffer.

## Structure
- Package scan_decoder_pkg holds:
  - typedef enum state_t {IDLE, DIRECT, SCAN}.
  - Constants MODE_DIRECT = 1'b0 and MODE_SCAN = 1'b1.
  - A parametrisable one-hot function onehot(idx).
- Sub-module dwell_timer (DWELL_W): a loadable down-counter with load, en and a zero-flag output, used by SCAN.
- FSM, index register and output register live in the top module.

## Test plan
- Reset with SEL_W = 2, then release, en = 0 -> y = 0000, idx = 0, wrap = 0, a_ready = 0.
- en = 1, mode = 0, transfers a = 2 then 3 on consecutive cycles -> y = 0100 then 1000, each one cycle after acceptance. Hold when a_valid = 0.
- mode = 1, dwell = 2 -> y steps 0001, 0010, 0100, 1000, 0001, each held 3 cycles. wrap is a single pulse on the return to 0001.
- dwell = 0 with SEL_W = 3 -> y advances every cycle through all 8 lines. wrap every 8 cycles.
- en dropped mid-scan at idx = 2 -> y = 0 next cycle. Re-enable restarts at idx 0 with no wrap pulse.
- rst_n pulsed low mid-scan, asynchronous to clk -> outputs clear before the next edge. Mode switch scan->direct with a simultaneous transfer a = 1 -> y = 0010 next cycle.
